// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin owner of the FIFO push port with bounded bursts (option FIFO_ARB_PRIO0_EN)
module fifo_push_arbiter #(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    input  logic                     ful,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic                     push,
    output logic [WIDTH-1:0]         w_data,
    output logic [$clog2(N_REQ)-1:0] owner
);
    localparam int OW = $clog2(N_REQ);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic [N_REQ-1:0] gnt_nx, cand;
    logic [OW-1:0] owner_nx, last, last_nx, win;
    logic [7:0] burst_cnt, cnt_nx;
    logic found, rel_a, rel_b, rel, arb;
    // state, grant and burst bookkeeping registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            last      <= OW'(N_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            owner     <= owner_nx;
            last      <= last_nx;
            burst_cnt <= cnt_nx;
        end
    end
    // release detection and round-robin search starting after the last owner
    always_comb begin
        rel_a = ~req[owner];
`ifdef FIFO_ARB_PRIO0_EN
        rel_b = push && burst_cnt == 8'(MAX_BURST - 1) && owner != '0;
`else
        rel_b = push && burst_cnt == 8'(MAX_BURST - 1);
`endif
        rel  = state == BURST && (rel_a || rel_b);
        arb  = state == IDLE || rel;
        cand = rel_b ? req & ~(N_REQ'(1) << owner) : req;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && cand[(int'(last) + k) % N_REQ]) begin
                found = 1'b1;
                win   = OW'((int'(last) + k) % N_REQ);
            end
        end
`ifdef FIFO_ARB_PRIO0_EN
        if (cand[0]) begin
            found = 1'b1;
            win   = '0;
        end
`endif
        state_nx = arb ? (found ? BURST : IDLE) : state;
        gnt_nx   = arb ? (found ? N_REQ'(1) << win : '0) : gnt;
        owner_nx = arb && found ? win : owner;
        last_nx  = rel ? owner : last;
        cnt_nx   = rel ? '0 : push ? burst_cnt + 8'd1 : burst_cnt;
    end
    // push port driven straight from the registered owner
    always_comb begin
        push   = state == BURST && req[owner] && !ful;
        ack    = push ? N_REQ'(1) << owner : '0;
        w_data = push ? wdata[owner*WIDTH +: WIDTH] : '0;
    end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed checks of grant order, bursts, stalls and reset
module tb_fifo_push_arbiter;
    logic        clk = 1'b0, reset_n;
    logic [3:0]  req, gnt, ack;
    logic [31:0] wdata;
    logic        ful, push;
    logic [7:0]  w_data;
    logic [1:0]  owner;
    int checks = 0, failures = 0;

    fifo_push_arbiter #(.WIDTH(8), .N_REQ(4), .MAX_BURST(4)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wdata(wdata), .ful(ful),
        .gnt(gnt), .ack(ack), .push(push), .w_data(w_data), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; req = '0; ful = 1'b0;
        wdata = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        tick(); tick();
        check("rst_gnt", gnt, 0);
        check("rst_push", push, 0);
        check("rst_ack", ack, 0);
        check("rst_wdata", w_data, 0);
        check("rst_owner", owner, 0);
        reset_n = 1'b1;
        // single requester, three words
        req = 4'b0001; wdata[7:0] = 8'hA1; #1;
        check("t1_idle_gnt", gnt, 0);
        check("t1_idle_push", push, 0);
        tick();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_push1", push, 1);
        check("t1_wd1", w_data, 8'hA1);
        check("t1_ack1", ack, 4'b0001);
        tick(); wdata[7:0] = 8'hA2; #1;
        check("t1_push2", push, 1);
        check("t1_wd2", w_data, 8'hA2);
        tick(); wdata[7:0] = 8'hA3; #1;
        check("t1_push3", push, 1);
        check("t1_wd3", w_data, 8'hA3);
        tick(); req = '0; #1;
        check("t1_nopush", push, 0);
        tick();
        check("t1_release", gnt, 0);
        wdata[7:0] = 8'hD0;
        // all requesting: four-word bursts, no bubbles
        do_reset();
        req = 4'b1111;
        tick();
        for (int c = 0; c < 20; c++) begin
            check("t2_owner", owner, (c / 4) % 4);
            check("t2_gnt", gnt, 32'd1 << ((c / 4) % 4));
            check("t2_push", push, 1);
            check("t2_wdata", w_data, 8'hD0 + (c / 4) % 4);
            tick();
        end
        check("t2_owner_next", owner, 1);
        req = '0;
        tick();
        check("t2_idle", gnt, 0);
        // stall with owner 2 mid-burst
        req = 4'b0100;
        tick();
        check("t3_gnt", gnt, 4'b0100);
        check("t3_push0", push, 1);
        tick();
        ful = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_push", push, 0);
            check("t3_stall_ack", ack, 0);
            check("t3_stall_gnt", gnt, 4'b0100);
            check("t3_stall_owner", owner, 2);
            tick();
        end
        ful = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("t3_resume_push", push, 1);
            check("t3_resume_wd", w_data, 8'hD2);
            tick();
        end
        check("t3_burst_end", gnt, 0);
        req = '0;
        // requester drops while stalled
        ful = 1'b1; req = 4'b0010;
        tick();
        check("t4_gnt1", gnt, 4'b0010);
        check("t4_push1", push, 0);
        req = 4'b1000; #1;
        check("t4_drop_push", push, 0);
        check("t4_drop_ack", ack, 0);
        tick();
        check("t4_gnt3", gnt, 4'b1000);
        check("t4_owner3", owner, 3);
        check("t4_stall3", push, 0);
        ful = 1'b0; #1;
        check("t4_push3", push, 1);
        check("t4_wd3", w_data, 8'hD3);
        check("t4_ack3", ack, 4'b1000);
        req = '0;
        tick();
        check("t4_idle", gnt, 0);
        // asynchronous reset mid-burst
        req = 4'b0100;
        tick();
        check("t5_gnt", gnt, 4'b0100);
        check("t5_push", push, 1);
        #3 reset_n = 1'b0;
        #1;
        check("t5_async_gnt", gnt, 0);
        check("t5_async_push", push, 0);
        check("t5_async_ack", ack, 0);
        check("t5_async_owner", owner, 0);
        req = 4'b1111;
        #2 reset_n = 1'b1;
        tick();
        check("t5_first_gnt", gnt, 4'b0001);
        check("t5_first_owner", owner, 0);
        req = '0;
        tick();
`ifdef FIFO_ARB_PRIO0_EN
        // requester 0 holds priority and ignores the burst limit
        do_reset();
        req = 4'b0111;
        tick();
        for (int c = 0; c < 10; c++) begin
            check("t6_prio_owner", owner, 0);
            check("t6_prio_push", push, 1);
            tick();
        end
        req = 4'b0110;
        tick();
        for (int c = 0; c < 12; c++) begin
            check("t6_rr_owner", owner, (c / 4) % 2 + 1);
            check("t6_rr_push", push, 1);
            tick();
        end
        req = '0;
        tick();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
